// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end for the 16-bit MIPS core. It issues sequential
//   word fetches over a req/ack bus and buffers each returned instruction,
//   tagged with its PC, in a small FIFO. The core drains the FIFO through a
//   valid/ready port. A redirect flushes the FIFO and discards any in-flight
//   fetch.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset (bit 0 must be 0)
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   mem_req         fetch request, held until mem_ack
//   mem_addr        byte address of the fetched word (bit 0 always 0)
//   mem_ack         completes the transfer when mem_req & mem_ack
//   mem_rdata       instruction word, valid in the ack cycle
//   redirect_valid  one-cycle pulse requesting a PC change
//   redirect_pc     new fetch address (bit 0 forced to 0)
//   instr_valid     FIFO head is valid
//   instr           FIFO head instruction (0 when not valid)
//   instr_pc        byte address of instr (0 when not valid)
//   instr_ready     core consumes the head when instr_valid & instr_ready
// ----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int              PTRW    = $clog2(DEPTH);
  localparam logic [PTRW:0]   LP_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   LP_ONE  = (PTRW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_mem_req;
  logic [15:0]     r_mem_addr;
  logic [15:0]     r_fetch_pc;

  logic [15:0]     r_pc_mem  [DEPTH];
  logic [15:0]     r_ins_mem [DEPTH];
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW:0]   r_count;

  logic [15:0]     w_rpc;
  logic [15:0]     w_pc_inc;
  logic            w_push;
  logic            w_pop;
  logic [PTRW:0]   w_count_next;
  logic            w_has_room;

  assign w_rpc    = redirect_pc & 16'hFFFE;
  assign w_pc_inc = r_fetch_pc + 16'd2;

  // A redirect both flushes and suppresses the push/pop of that same cycle.
  assign w_push = (r_state == S_REQ) & mem_ack & ~redirect_valid;
  assign w_pop  = (r_count != '0) & instr_ready & ~redirect_valid;

  always_comb begin
    w_count_next = r_count;
    if (redirect_valid)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + LP_ONE;
    else if (!w_push && w_pop)
      w_count_next = r_count - LP_ONE;
  end

  // Room is judged on the post-push/pop occupancy so a pop re-arms fetch
  // on the very next cycle.
  assign w_has_room = (w_count_next < LP_FULL);

  // Fetch control FSM; mem_req/mem_addr are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_rpc;
            r_mem_addr <= w_rpc;
          end else if (w_has_room) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_rpc;
            if (mem_ack)
              r_mem_addr <= w_rpc;   // transfer done, restart at new PC
            else
              r_state    <= S_DROP;  // stale request stays on the bus
          end else if (mem_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_mem_addr <= w_pc_inc;
            if (!w_has_room) begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (redirect_valid)
            r_fetch_pc <= w_rpc;
          if (mem_ack) begin
            r_state    <= S_REQ;
            r_mem_addr <= redirect_valid ? w_rpc : r_fetch_pc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are qualified by r_count so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
      r_ins_mem[r_wr_ptr] <= mem_rdata;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_ins_mem[r_rd_ptr] : '0;
  assign instr_pc    = instr_valid ? r_pc_mem[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue. A behavioural model (bus-busy flag,
//   stale flag, next PC and a queue of {pc, instr}) predicts every output
//   after each clock edge; directed scenarios add explicit checks on top.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_req;
  logic        m_stale;
  logic [15:0] m_addr;
  logic [15:0] m_pc;
  logic [31:0] q[$];

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req   = 1'b0;
    m_stale = 1'b0;
    m_addr  = RESET_PC;
    m_pc    = RESET_PC;
  endtask

  // Applies one clock edge worth of behaviour using the inputs held across it.
  task automatic model_update();
    logic [15:0] npc;
    logic        fire;
    npc  = redirect_pc & 16'hFFFE;
    fire = m_req && mem_ack;
    if (redirect_valid)
      q.delete();
    else if (q.size() != 0 && instr_ready)
      void'(q.pop_front());
    if (fire && !m_stale && !redirect_valid)
      q.push_back({m_addr, mem_rdata});
    if (m_req && !mem_ack) begin
      if (redirect_valid) begin
        m_stale = 1'b1;
        m_pc    = npc;
      end
    end else begin
      if (redirect_valid)
        m_pc = npc;
      else if (fire && !m_stale)
        m_pc = m_addr + 16'd2;
      m_stale = 1'b0;
      m_req   = (!m_req && redirect_valid) ? 1'b0 : (q.size() < DEPTH);
      m_addr  = m_pc;
    end
  endtask

  task automatic check_all();
    logic [31:0] head;
    head = (q.size() != 0) ? q[0] : 32'h0;
    chk("mem_req",     {15'd0, mem_req},     {15'd0, m_req});
    chk("mem_addr",    mem_addr,             m_addr);
    chk("instr_valid", {15'd0, instr_valid}, {15'd0, (q.size() != 0)});
    chk("instr",       instr,                head[15:0]);
    chk("instr_pc",    instr_pc,             head[31:16]);
  endtask

  task automatic step(input logic ack, input logic rdy, input logic rv, input logic [15:0] rpc);
    mem_ack        = ack;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_rdata      = 16'($urandom);
    @(posedge clk);
    model_update();
    #1;
    check_all();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    mem_ack        = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #1;
    chk("rst_mem_req",     {15'd0, mem_req},     16'd0);
    chk("rst_mem_addr",    mem_addr,             RESET_PC);
    chk("rst_instr_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_instr",       instr,                16'd0);
    chk("rst_instr_pc",    instr_pc,             16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_mem_req", {15'd0, mem_req}, 16'd0);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  logic [15:0] wrap_exp [4];

  initial begin
    wrap_exp = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};

    // Reset, then zero-wait streaming
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("stream_addr", mem_addr, 16'h000E);
    chk("stream_pc",   instr_pc, 16'h000C);

    // Full FIFO under backpressure
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("full_req_low", {15'd0, mem_req}, 16'd0);
    chk("full_head",    instr_pc,         16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("resume_req",  {15'd0, mem_req}, 16'd1);
    chk("resume_addr", mem_addr,         16'h0008);
    chk("pop1_pc",     instr_pc,         16'h0002);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    // Redirect while a fetch is outstanding
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0041);
    chk("drop_addr",  mem_addr,             16'h0004);
    chk("drop_valid", {15'd0, instr_valid}, 16'd0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("drop_new_addr", mem_addr,             16'h0040);
    chk("drop_discard",  {15'd0, instr_valid}, 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("drop_first_pc", instr_pc, 16'h0040);

    // Redirect coincident with ack
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("pre_redir_addr", mem_addr, 16'h000A);
    step(1'b1, 1'b1, 1'b1, 16'h0100);
    chk("redir_ack_addr",  mem_addr,             16'h0100);
    chk("redir_ack_valid", {15'd0, instr_valid}, 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("redir_ack_pc", instr_pc, 16'h0100);

    // Address wrap-around
    step(1'b1, 1'b1, 1'b1, 16'hFFFC);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("wrap_pc", instr_pc, wrap_exp[i]);
    end

    // Reset with a half-full FIFO and a fetch outstanding
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("restart_addr", mem_addr, RESET_PC);

    // Reset while dropping a stale fetch
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0300);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("restart2_req", {15'd0, mem_req}, 16'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic        a, r, rv;
      logic [15:0] rpc;
      a   = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 9) < 5);
      rv  = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (16'hFFF8 | 16'($urandom_range(0, 7)))
                                        : 16'($urandom);
      step(a, r, rv, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end for the 16-bit MIPS core. It generates sequential word addresses and requests instructions over a req/ack bus. Returned instructions go into a small FIFO with their PC attached. The core drains the FIFO through a valid/ready port, and can redirect fetch (jump, jr, taken beq) at any time, which flushes the FIFO and any in-flight fetch.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 16'h0000: first fetch address after reset; bit 0 must be 0.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_addr  out  16  byte address of the fetched word; bit 0 always 0.
- mem_ack  in  1  transfer completes in any cycle where mem_req & mem_ack.
- mem_rdata  in  16  instruction word; valid in the ack cycle.
- redirect_valid  in  1  one-cycle pulse requesting a PC change.
- redirect_pc  in  16  new fetch address; bit 0 ignored (forced 0).
- instr_valid  out  1  FIFO head is valid.
- instr  out  16  FIFO head instruction.
- instr_pc  out  16  byte address of instr.
- instr_ready  in  1  core consumes the head when instr_valid & instr_ready.

## Operation
- **Registers**
  - fetch_pc: next address to request.
  - FIFO: DEPTH × {pc, instr}, with rd/wr pointers and a count.
  - 2-bit state.
- **States**
  - IDLE: mem_req=0.
  - REQ: mem_req=1, mem_addr=fetch_pc.
  - DROP: mem_req=1, mem_addr=the stale address; the next returned word is discarded.
- **IDLE → REQ** when count < DEPTH and no redirect is pending. A redirect in IDLE loads fetch_pc and stays in IDLE for that cycle.
- **REQ, ack, no redirect**
  - Push {fetch_pc, mem_rdata}.
  - fetch_pc += 2, with 16-bit wrap: FFFE → 0000.
  - Stay in REQ if the post-push/pop count < DEPTH, else go to IDLE.
- **REQ, no ack, no redirect:** hold; mem_addr must not change.
- **REQ, redirect, no ack**
  - Go to DROP.
  - fetch_pc = redirect_pc & FFFE.
  - Flush the FIFO.
- **REQ, redirect and ack in the same cycle**
  - Do not push the returned word.
  - Flush the FIFO.
  - fetch_pc = redirect_pc & FFFE.
  - Go to REQ (the FIFO is now empty).
- **DROP**
  - Hold the stale address until ack, then discard the data and go to REQ.
  - A further redirect while in DROP only updates fetch_pc.
  - A request is never abandoned before its ack.
- **Flush**
  - Count becomes 0; pointers are reset.
  - The core's pop is ignored in the redirect cycle.
- **FIFO**
  - Push and pop in the same cycle leave count unchanged.
  - Pushes never occur at full, because a request is issued only when count < DEPTH. At most one fetch is outstanding.
- **Outputs**
  - instr_valid = (count != 0).
  - instr and instr_pc are the head entry.
  - When instr_valid=0, instr and instr_pc are don't-care and are driven 0.

## Timing
- **Reset (asynchronous assert)**
  - state=IDLE, mem_req=0, mem_addr=RESET_PC.
  - fetch_pc=RESET_PC, count=0, instr_valid=0, instr=0, instr_pc=0.
- **After reset release:** mem_req=1 from the cycle after the first rising edge.
- **Zero-wait memory** (ack whenever req is high): one instruction per cycle.
  - mem_addr increments every cycle.
  - A word acked in cycle n is visible at instr on cycle n+1.
- **Redirect latency**
  - Redirect in cycle n, no outstanding fetch, or ack coincident: mem_addr=redirect_pc at n+1.
  - Otherwise the new address appears the cycle after the stale ack.
  - instr_valid=0 at n+1 in all cases.
- **Backpressure:** with instr_ready=0, mem_req drops the cycle after the DEPTH-th push. It re-asserts the cycle after the first pop.
- **Reset mid-transfer:** all state clears at once. The bus is released (mem_req=0) and any pending ack is ignored.
- **Registered outputs:** mem_req and mem_addr are decoded from registered state only, with no combinational path from mem_ack.

## Test plan
- **Reset:** hold reset_n=0 → every output equals its reset value. Release with ack=1 and ready=1 → mem_addr runs 0000, 0002, 0004, …; instr_pc lags mem_addr by one cycle.
- **Full FIFO:** ready=0, ack=1, DEPTH=4 → 4 pushes (pc 0–6), then mem_req=0. Assert ready → instr_pc pops 0000, 0002, 0004, 0006 in order, and fetch resumes at 0008.
- **Redirect mid-fetch:** ack held 0 at address 0004, pulse redirect to 0x0041 → mem_addr stays 0004 and instr_valid=0. After the ack, the 0004 data is never output and the next mem_addr is 0040.
- **Redirect with ack:** redirect to 0x0100 in the same cycle as the ack of 000A → the 000A word is dropped and mem_addr=0100 in the next cycle.
- **Wrap-around:** redirect to FFFC with zero-wait memory → instr_pc sequence FFFC, FFFE, 0000, 0002.
- **Reset mid-operation:** assert reset_n=0 in DROP with a half-full FIFO → immediately mem_req=0 and instr_valid=0. After release, fetch restarts at RESET_PC.
